dmem_responder: RTL and testbench

//  Data-memory responder on the far side of the pipeline's DM_* interface.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Slow data-memory responder: accepts one load/store, stalls the requester for LATENCY wait states,
// then completes with registered read data. Optional misalignment trap under DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int N       = 64,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         DM_stall,
  output logic         DM_rvalid,
  output logic         DM_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic             wr;
    logic             mis;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     data;
  } req_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic [N-1:0]     rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             err_d;
  logic             mem_we;
  logic             req;
  logic             mis_in;

  logic [N-1:0] mem [DEPTH];

  assign req = DM_readEnable | DM_writeEnable;

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  logic unused_addr_hi;
  assign mis_in         = (DM_addr[2:0] != 3'd0);
  assign unused_addr_hi = ^DM_addr[N-1:IDX_W+3];
  assign DM_err         = err_q;
`else
  logic unused_addr_bits;
  assign mis_in           = 1'b0;
  assign unused_addr_bits = ^{DM_addr[N-1:IDX_W+3], DM_addr[2:0]};
  assign DM_err           = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    mem_we   = 1'b0;
    DM_stall = 1'b0;
    case (state_q)
      IDLE: begin
        DM_stall = req;
        if (req) begin
          // a store wins when both enables are set
          req_d.wr   = DM_writeEnable;
          req_d.mis  = mis_in;
          req_d.idx  = DM_addr[IDX_W+2:3];
          req_d.data = DM_writeData;
          cnt_d      = LAT_M1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        DM_stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
          if (req_q.mis) begin
            err_d = 1'b1;
          end else if (req_q.wr) begin
            mem_we = 1'b1;
          end else begin
            rdata_d  = mem[req_q.idx];
            rvalid_d = 1'b1;
          end
        end
      end
      DONE: begin
        // requester advances on this edge; any request seen now is dropped
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  logic unused_err;
  assign unused_err = err_d;
`endif

  // storage is not reset; a reset on the commit edge discards the store
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[req_q.idx] <= req_q.data;
  end

  assign DM_readData = rdata_q;
  assign DM_rvalid   = rvalid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboard of expected load data, stall length and pulse checks.
module tb_dmem_responder;

  localparam int N     = 64;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] DM_addr, DM_writeData, DM_readData;
  logic         DM_writeEnable, DM_readEnable, DM_stall, DM_rvalid, DM_err;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] model [DEPTH];
  logic [N-1:0] sb [$];
  logic [N-1:0] last_rd;

  always #5 clk = ~clk;

  dmem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .DM_addr(DM_addr), .DM_writeData(DM_writeData),
    .DM_writeEnable(DM_writeEnable), .DM_readEnable(DM_readEnable),
    .DM_readData(DM_readData), .DM_stall(DM_stall), .DM_rvalid(DM_rvalid), .DM_err(DM_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic rd, input logic [63:0] addr, input logic [63:0] data);
    int idx;
    int nst;
    bit bad;
    logic [63:0] exp;
    idx = int'((addr >> 3) & 64'(DEPTH - 1));
    bad = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    bad = (addr[2:0] != 3'd0);
`endif
    if (!bad) begin
      if (wr) model[idx] = data;
      else if (rd) sb.push_back(model[idx]);
    end
    @(negedge clk);
    DM_addr = addr; DM_writeData = data; DM_writeEnable = wr; DM_readEnable = rd;
    #1;
    nst = 0;
    while (DM_stall === 1'b1 && nst < 20) begin
      nst++;
      @(posedge clk); #1;
      // latched request must not follow the bus once in WAIT
      if (nst == 1) begin DM_addr = ~addr; DM_writeData = ~data; end
    end
    check("stall_len", 64'(nst), 64'(LAT + 1));
    check("rvalid", 64'(DM_rvalid), 64'(rd && !wr && !bad));
    check("err", 64'(DM_err), 64'(bad));
    if (DM_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        exp = sb.pop_front();
        check("rdata", DM_readData, exp);
        last_rd = exp;
      end
    end else begin
      check("rdata_hold", DM_readData, last_rd);
    end
    DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
    @(posedge clk); #1;
    check("rvalid_pulse", 64'(DM_rvalid), 64'd0);
    check("idle_stall", 64'(DM_stall), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    DM_addr = '0; DM_writeData = '0; DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", DM_readData, 64'd0);
    check("rst_stall", 64'(DM_stall), 64'd0);
    check("rst_rvalid", 64'(DM_rvalid), 64'd0);
    check("rst_err", 64'(DM_err), 64'd0);
    @(negedge clk); reset = 1'b0;

    // basic write then read
    access(1'b1, 1'b0, 64'h18, 64'hDEAD_BEEF_0123_4567);
    access(1'b0, 1'b1, 64'h18, 64'h0);

    // both enables: store, no load
    access(1'b1, 1'b1, 64'h20, 64'h55);
    access(1'b0, 1'b1, 64'h20, 64'h0);

    // address wrap modulo DEPTH*8
    access(1'b1, 1'b0, 64'h008, 64'hAA);
    access(1'b0, 1'b1, 64'h208, 64'h0);

    // top word boundary
    access(1'b1, 1'b0, 64'h1F8, 64'h0F0F_1234_5678_9ABC);
    access(1'b0, 1'b1, 64'h1F8, 64'h0);

    // reset on the commit edge of a store
    access(1'b1, 1'b0, 64'h10, 64'h1111);
    @(negedge clk);
    DM_addr = 64'h10; DM_writeData = 64'h77; DM_writeEnable = 1'b1; DM_readEnable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait2_stall", 64'(DM_stall), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; DM_writeEnable = 1'b0;
    #1;
    check("midrst_stall", 64'(DM_stall), 64'd0);
    check("midrst_rdata", DM_readData, 64'd0);
    check("midrst_rvalid", 64'(DM_rvalid), 64'd0);
    check("midrst_err", 64'(DM_err), 64'd0);
    last_rd = '0;
    access(1'b0, 1'b1, 64'h10, 64'h0);

    // misaligned load
    access(1'b0, 1'b1, 64'h13, 64'h0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
